// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Constants shared by the 3x3 window generator and the convolution filter.
//   DATA_W        : pixel width in bits
//   WIN_TL..WIN_BR: row-major index of each tap in the 3x3 window
//                   (TL = oldest row/oldest column, BR = newest pixel)
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int DATA_W = 12;

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  localparam int WIN_TAPS = 9;

endpackage

// File: rtl/conv_window_gen_if.sv
// ---------------------------------------------------------------------------
// conv_window_gen_if
// Pixel stream in, 3x3 window out.
//   master : pixel source / window consumer (drives sof, pix_valid, pix_in)
//   slave  : conv_window_gen (drives win_valid, x0..x8, win_row, win_col)
//
// Handshake: a pixel is transferred on every rising clk edge where
// pix_valid=1; there is no ready, the generator accepts every valid pixel.
// win_valid=1 marks x0..x8/win_row/win_col as one complete window for that
// single cycle; the consumer must take it then (no backpressure).
// ---------------------------------------------------------------------------
interface conv_window_gen_if #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic              sof;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_in;

  logic              win_valid;
  logic [DATA_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7, x8;
  logic [RW-1:0]     win_row;
  logic [CW-1:0]     win_col;

  modport master (
    output sof, pix_valid, pix_in,
    input  win_valid, x0, x1, x2, x3, x4, x5, x6, x7, x8, win_row, win_col
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output win_valid, x0, x1, x2, x3, x4, x5, x6, x7, x8, win_row, win_col
  );

endinterface

// File: rtl/conv_line_buffer.sv
// ---------------------------------------------------------------------------
// conv_line_buffer
// One image row of delay: IMG_W x DATA_W single-port memory addressed by
// column. rd_data is the word currently stored at addr (the value written one
// row earlier); when en=1 the new word replaces it at the clock edge, so a
// read and write to the same column in one cycle returns the old value.
//   clk     : clock
//   en      : write enable (accepted pixel)
//   addr    : column index
//   wr_data : word to store
//   rd_data : word stored at addr before this cycle's write
// Contents are never cleared; consumers mask stale data.
// ---------------------------------------------------------------------------
module conv_line_buffer #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_W  = 640
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [IMG_W];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
// Turns a raster-order pixel stream into registered 3x3 neighbourhoods.
// Two line buffers hold the previous two rows; a 3x3 shift register slides
// one column per accepted pixel. Window outputs update on the same edge that
// accepts the pixel.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (counters, window, valid)
//   bus : conv_window_gen_if.slave
//         in : sof, pix_valid, pix_in
//         out: win_valid, x0..x8 (row-major, x8 = newest), win_row, win_col
//              (position of centre tap x4)
// ---------------------------------------------------------------------------
module conv_window_gen #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  conv_window_gen_if.slave  bus
);
  import conv_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Position the next pixel will take if it arrives without sof.
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  // Position of the pixel on the bus this cycle.
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  logic              accept;
  logic [DATA_W-1:0] lb0_q;  // pixel at (row-1, col)
  logic [DATA_W-1:0] lb1_q;  // pixel at (row-2, col)

  logic [DATA_W-1:0] win [WIN_TAPS];
  logic              win_valid_q;
  logic [RW-1:0]     win_row_q;
  logic [CW-1:0]     win_col_q;

  assign accept = bus.pix_valid;

  // sof overrides the counters so a frame can restart at any point.
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (bus.sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  // lb1 is fed from lb0's old value, forming a two-row delay chain.
  conv_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb0 (
    .clk     (clk),
    .en      (accept),
    .addr    (cur_col),
    .wr_data (bus.pix_in),
    .rd_data (lb0_q)
  );

  conv_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb1 (
    .clk     (clk),
    .en      (accept),
    .addr    (cur_col),
    .wr_data (lb0_q),
    .rd_data (lb1_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      for (int i = 0; i < WIN_TAPS; i++) begin
        win[i] <= '0;
      end
    end else begin
      win_valid_q <= 1'b0;
      if (accept) begin
        if (cur_col == COL_LAST) begin
          col_q <= '0;
          row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col_q <= cur_col + CW'(1);
          row_q <= cur_row;
        end

        // Shift each window row left; new right column comes from the
        // line buffers and the incoming pixel.
        win[WIN_TL] <= win[WIN_TC];
        win[WIN_TC] <= win[WIN_TR];
        win[WIN_TR] <= lb1_q;
        win[WIN_ML] <= win[WIN_C];
        win[WIN_C]  <= win[WIN_MR];
        win[WIN_MR] <= lb0_q;
        win[WIN_BL] <= win[WIN_BC];
        win[WIN_BC] <= win[WIN_BR];
        win[WIN_BR] <= bus.pix_in;

        // Only windows whose three columns and three rows all lie in the
        // current frame and row are flagged; row/col are kept otherwise.
        if (cur_row >= RW'(2) && cur_col >= CW'(2)) begin
          win_valid_q <= 1'b1;
          win_row_q   <= cur_row - RW'(1);
          win_col_q   <= cur_col - CW'(1);
        end
      end
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.x0        = win[WIN_TL];
  assign bus.x1        = win[WIN_TC];
  assign bus.x2        = win[WIN_TR];
  assign bus.x3        = win[WIN_ML];
  assign bus.x4        = win[WIN_C];
  assign bus.x5        = win[WIN_MR];
  assign bus.x6        = win[WIN_BL];
  assign bus.x7        = win[WIN_BC];
  assign bus.x8        = win[WIN_BR];

endmodule

// File: tb/tb_conv_window_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_window_gen
// Directed bench on a 4x4 image where pixel (r,c) = offset + 4r + c + 1.
// A full frame yields four windows whose top-left pixels are offset+1, +2,
// +5, +6 with centres (1,1), (1,2), (2,1), (2,2); each tap of a window is
// its top-left value plus {0,1,2,4,5,6,8,9,10}.
// ---------------------------------------------------------------------------
module tb_conv_window_gen;

  localparam int DW = 12;
  localparam int IW = 4;
  localparam int IH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) bus ();

  conv_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int win_cnt = 0;

  // scoreboard entry: {win_row[1:0], win_col[1:0], top-left pixel[11:0]}
  logic [15:0] exp_q[$];

  logic [DW-1:0] xs [9];
  assign xs[0] = bus.x0;
  assign xs[1] = bus.x1;
  assign xs[2] = bus.x2;
  assign xs[3] = bus.x3;
  assign xs[4] = bus.x4;
  assign xs[5] = bus.x5;
  assign xs[6] = bus.x6;
  assign xs[7] = bus.x7;
  assign xs[8] = bus.x8;

  int offs [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare any flagged window against the head of the expected queue.
  task automatic monitor();
    logic [15:0] e;
    if (bus.win_valid === 1'b1) begin
      win_cnt++;
      check("win_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 9; k++) begin
          check($sformatf("x%0d", k), 32'(xs[k]), 32'(e[11:0]) + 32'(offs[k]));
        end
        check("win_row", 32'(bus.win_row), 32'(e[15:14]));
        check("win_col", 32'(bus.win_col), 32'(e[13:12]));
      end
    end
  endtask

  // driver tasks
  task automatic send(input int p, input logic s);
    bus.pix_in    = DW'(p);
    bus.sof       = s;
    bus.pix_valid = 1'b1;
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic idle(input int n, input logic hold_chk, input int hold_base);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("stall_valid", 32'(bus.win_valid), 32'd0);
      if (hold_chk) begin
        check("stall_x0", 32'(xs[0]), 32'(hold_base));
        check("stall_x8", 32'(xs[8]), 32'(hold_base + 10));
      end
    end
  endtask

  task automatic send_frame(input int offset, input logic first_sof);
    for (int i = 0; i < IW * IH; i++) begin
      send(offset + i + 1, first_sof && (i == 0));
    end
  endtask

  task automatic expect_frame(input int offset);
    exp_q.push_back({2'd1, 2'd1, 12'(offset + 1)});
    exp_q.push_back({2'd1, 2'd2, 12'(offset + 2)});
    exp_q.push_back({2'd2, 2'd1, 12'(offset + 5)});
    exp_q.push_back({2'd2, 2'd2, 12'(offset + 6)});
  endtask

  task automatic end_test(input string tag, input int n);
    check({tag, "_win_count"}, 32'(win_cnt), 32'(n));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    win_cnt = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(bus.win_valid), 32'd0);
    check({tag, "_row"}, 32'(bus.win_row), 32'd0);
    check({tag, "_col"}, 32'(bus.win_col), 32'd0);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("%s_x%0d", tag, k), 32'(xs[k]), 32'd0);
    end
  endtask

  initial begin
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    rst = 1'b0;

    // Full frame, continuous valid: four windows, none on cols 0/1.
    expect_frame(0);
    send_frame(0, 1'b1);
    idle(1, 1'b0, 0);
    end_test("frame", 4);

    // Three-cycle stall after pixel 11: window held, valid low.
    expect_frame(0);
    for (int i = 1; i <= 11; i++) send(i, i == 1);
    idle(3, 1'b1, 1);
    for (int i = 12; i <= 16; i++) send(i, 1'b0);
    idle(1, 1'b0, 0);
    end_test("stall", 4);

    // Back-to-back frames, second one +100 with sof.
    expect_frame(0);
    expect_frame(100);
    send_frame(0, 1'b1);
    send_frame(100, 1'b1);
    idle(1, 1'b0, 0);
    end_test("b2b", 8);

    // Reset after pixel 7, restart without sof.
    for (int i = 1; i <= 7; i++) send(i, i == 1);
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("rst1");
    expect_frame(200);
    send_frame(200, 1'b0);
    idle(1, 1'b0, 0);
    end_test("restart", 4);

    // sof on the 6th pixel of a frame restarts at (0,0).
    for (int i = 1; i <= 5; i++) send(300 + i, i == 1);
    expect_frame(400);
    send_frame(400, 1'b1);
    idle(1, 1'b0, 0);
    end_test("midsof", 4);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
